// File: rtl/obj_pkg.sv
// Shared definitions for the object spawner: slot state encoding, LFSR mask,
// coordinate and counter widths.
package obj_pkg;

  typedef enum logic [2:0] {
    SlotIdle,
    SlotWait,
    SlotLoad,
    SlotArm,
    SlotFly
  } slot_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned CNT_W     = 16;

  // One right-shifting Galois step; the bit shifted out folds the mask back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used as the spawner's randomness source.
module lfsr16
  import obj_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/object_spawner.sv
// Launches up to N_OBJ objects: per-slot delay/launch FSMs sharing one LFSR, with a
// lowest-index-first arbiter so only one slot captures launch values per cycle.
module object_spawner
  import obj_pkg::*;
#(
  parameter int unsigned   N_OBJ     = 4,
  parameter int unsigned   DEPTH_BIT = 18,
  parameter int unsigned   DLY_MIN   = 16,
  parameter logic [15:0]   LFSR_SEED = 16'hACE1,
  parameter int unsigned   SPR_ADDR0 = 0,
  parameter int unsigned   SPR_ADDR1 = 8000,
  parameter int unsigned   SPR_ADDR2 = 16000,
  parameter int unsigned   SPR_ADDR3 = 26000,
  parameter int unsigned   INIT_POSY = 375
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           enable,
  input  logic [N_OBJ-1:0]               oob,
  output logic [N_OBJ-1:0]               obj_rst,
  output logic [N_OBJ-1:0]               move,
  output logic [COORD_W*N_OBJ-1:0]       initposx,
  output logic [COORD_W*N_OBJ-1:0]       initposy,
  output logic [COORD_W*N_OBJ-1:0]       initvx,
  output logic [COORD_W*N_OBJ-1:0]       initvy,
  output logic [N_OBJ-1:0]               initdx,
  output logic [DEPTH_BIT*N_OBJ-1:0]     addr,
  output logic [15:0]                    spawn_count
);

  logic [15:0]          lfsr;
  logic [N_OBJ-1:0]     req;
  logic [N_OBJ-1:0]     gnt;
  logic [15:0]          spawn_q;

  logic [COORD_W-1:0]   launch_posx;
  logic [COORD_W-1:0]   launch_vx;
  logic [COORD_W-1:0]   launch_vy;
  logic [DEPTH_BIT-1:0] launch_addr;
  logic [CNT_W-1:0]     reload_cnt;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (1'b1),
    .state (lfsr)
  );

  // Launch values are derived from whatever the LFSR holds in the grant cycle.
  assign launch_posx = COORD_W'(64) + {1'b0, lfsr[7:0], 1'b0};
  assign launch_vx   = COORD_W'(1) + {7'd0, lfsr[10:8]};
  assign launch_vy   = COORD_W'(4) + {8'd0, lfsr[13:12]};
  assign reload_cnt  = CNT_W'(DLY_MIN) + {8'd0, lfsr[7:0]};

  always_comb begin
    launch_addr = DEPTH_BIT'(SPR_ADDR0);
    unique case (lfsr[15:14])
      2'd0: launch_addr = DEPTH_BIT'(SPR_ADDR0);
      2'd1: launch_addr = DEPTH_BIT'(SPR_ADDR1);
      2'd2: launch_addr = DEPTH_BIT'(SPR_ADDR2);
      2'd3: launch_addr = DEPTH_BIT'(SPR_ADDR3);
    endcase
  end

  // Fixed-priority arbiter: lowest-index requester wins.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spawn_q <= '0;
    end else if (|gnt) begin
      spawn_q <= spawn_q + 16'd1;
    end
  end

  assign spawn_count = spawn_q;

  for (genvar g = 0; g < int'(N_OBJ); g++) begin : g_slot
    localparam logic [CNT_W-1:0] STAGGER = CNT_W'(DLY_MIN * (g + 1));

    slot_state_e          st_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 obj_rst_q;
    logic                 move_q;
    logic [COORD_W-1:0]   posx_q;
    logic [COORD_W-1:0]   posy_q;
    logic [COORD_W-1:0]   vx_q;
    logic [COORD_W-1:0]   vy_q;
    logic                 dx_q;
    logic [DEPTH_BIT-1:0] addr_q;

    assign req[g] = (st_q == SlotLoad) && enable;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q      <= SlotIdle;
        cnt_q     <= '0;
        obj_rst_q <= 1'b1;
        move_q    <= 1'b0;
        posx_q    <= '0;
        posy_q    <= '0;
        vx_q      <= '0;
        vy_q      <= '0;
        dx_q      <= 1'b0;
        addr_q    <= '0;
      end else begin
        unique case (st_q)
          SlotIdle: begin
            if (enable) begin
              st_q  <= SlotWait;
              cnt_q <= STAGGER;
            end
          end
          SlotWait: begin
            if (!enable) begin
              st_q <= SlotIdle;
            end else if (cnt_q == '0) begin
              st_q <= SlotLoad;
            end else if (tick) begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          SlotLoad: begin
            if (!enable) begin
              st_q <= SlotIdle;
            end else if (gnt[g]) begin
              posx_q <= launch_posx;
              posy_q <= COORD_W'(INIT_POSY);
              vx_q   <= launch_vx;
              vy_q   <= launch_vy;
              dx_q   <= lfsr[11];
              addr_q <= launch_addr;
              st_q   <= SlotArm;
            end
          end
          SlotArm: begin
            st_q      <= SlotFly;
            obj_rst_q <= 1'b0;
            move_q    <= 1'b1;
          end
          SlotFly: begin
            // A flying object always finishes; enable only decides whether it respawns.
            if (oob[g]) begin
              obj_rst_q <= 1'b1;
              move_q    <= 1'b0;
              if (enable) begin
                st_q  <= SlotWait;
                cnt_q <= reload_cnt;
              end else begin
                st_q <= SlotIdle;
              end
            end
          end
          default: begin
            st_q      <= SlotIdle;
            obj_rst_q <= 1'b1;
            move_q    <= 1'b0;
          end
        endcase
      end
    end

    assign obj_rst[g]                          = obj_rst_q;
    assign move[g]                             = move_q;
    assign initposx[g*COORD_W +: COORD_W]      = posx_q;
    assign initposy[g*COORD_W +: COORD_W]      = posy_q;
    assign initvx[g*COORD_W +: COORD_W]        = vx_q;
    assign initvy[g*COORD_W +: COORD_W]        = vy_q;
    assign initdx[g]                           = dx_q;
    assign addr[g*DEPTH_BIT +: DEPTH_BIT]      = addr_q;
  end

endmodule

// File: tb/tb_object_spawner.sv
// Randomised self-checking bench for object_spawner against a behavioural slot model.
module tb_object_spawner;

  localparam int N  = 4;
  localparam int DB = 18;
  localparam int DLY = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int PY = 375;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_LOAD = 2;
  localparam int M_ARM  = 3;
  localparam int M_FLY  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic              enable = 1'b0;
  logic [N-1:0]      oob = '0;
  logic [N-1:0]      obj_rst;
  logic [N-1:0]      move;
  logic [10*N-1:0]   initposx, initposy, initvx, initvy;
  logic [N-1:0]      initdx;
  logic [DB*N-1:0]   addr;
  logic [15:0]       spawn_count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [15:0]   m_lfsr;
  int            m_st  [N];
  int            m_cnt [N];
  logic [9:0]    m_px [N], m_py [N], m_vx [N], m_vy [N];
  logic          m_dx [N];
  logic [DB-1:0] m_ad [N];
  logic [15:0]   m_spawn;

  // Expected outputs assembled from the model
  logic [N-1:0]    e_rst, e_move, e_dx;
  logic [10*N-1:0] e_px, e_py, e_vx, e_vy;
  logic [DB*N-1:0] e_ad;

  object_spawner #(
    .N_OBJ     (N),
    .DEPTH_BIT (DB),
    .DLY_MIN   (DLY),
    .LFSR_SEED (SEED),
    .SPR_ADDR0 (0),
    .SPR_ADDR1 (8000),
    .SPR_ADDR2 (16000),
    .SPR_ADDR3 (26000),
    .INIT_POSY (PY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .enable      (enable),
    .oob         (oob),
    .obj_rst     (obj_rst),
    .move        (move),
    .initposx    (initposx),
    .initposy    (initposy),
    .initvx      (initvx),
    .initvy      (initvy),
    .initdx      (initdx),
    .addr        (addr),
    .spawn_count (spawn_count)
  );

  always #5 clk = ~clk;

  function automatic int spr_of(input logic [1:0] s);
    case (s)
      2'd0:    return 0;
      2'd1:    return 8000;
      2'd2:    return 16000;
      default: return 26000;
    endcase
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED;
    m_spawn = 0;
    for (int i = 0; i < N; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0;
      m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_dx[i] = 0; m_ad[i] = 0;
    end
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input logic en, input logic tk, input logic [N-1:0] ob);
    logic [15:0] l;
    bit granted;
    l = m_lfsr;
    granted = 0;
    for (int i = 0; i < N; i++) begin
      case (m_st[i])
        M_IDLE: if (en) begin m_st[i] = M_WAIT; m_cnt[i] = DLY * (i + 1); end
        M_WAIT: begin
          if (!en) m_st[i] = M_IDLE;
          else if (m_cnt[i] == 0) m_st[i] = M_LOAD;
          else if (tk) m_cnt[i] = m_cnt[i] - 1;
        end
        M_LOAD: begin
          if (!en) m_st[i] = M_IDLE;
          else if (!granted) begin
            granted = 1;
            m_px[i] = 10'(64 + 2 * int'(l[7:0]));
            m_py[i] = 10'(PY);
            m_vx[i] = 10'(1 + int'(l[10:8]));
            m_vy[i] = 10'(4 + int'(l[13:12]));
            m_dx[i] = l[11];
            m_ad[i] = DB'(spr_of(l[15:14]));
            m_st[i] = M_ARM;
            m_spawn = m_spawn + 16'd1;
          end
        end
        M_ARM: m_st[i] = M_FLY;
        default: begin
          if (ob[i]) begin
            if (en) begin m_st[i] = M_WAIT; m_cnt[i] = DLY + int'(l[7:0]); end
            else m_st[i] = M_IDLE;
          end
        end
      endcase
    end
    m_lfsr = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic model_expect();
    for (int i = 0; i < N; i++) begin
      e_rst[i]  = (m_st[i] != M_FLY);
      e_move[i] = (m_st[i] == M_FLY);
      e_dx[i]   = m_dx[i];
      e_px[i*10 +: 10] = m_px[i];
      e_py[i*10 +: 10] = m_py[i];
      e_vx[i*10 +: 10] = m_vx[i];
      e_vy[i*10 +: 10] = m_vy[i];
      e_ad[i*DB +: DB] = m_ad[i];
    end
  endtask

  // Drive inputs just after a falling edge, step the model, land on the next falling edge.
  task automatic drive_cycle(input logic en, input logic tk, input logic [N-1:0] ob);
    enable = en; tick = tk; oob = ob;
    model_step(en, tk, ob);
    @(negedge clk);
    model_expect();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 0; tick = 0; oob = '0;
    repeat (3) @(negedge clk);
    model_reset();
    n_checks += 9;
    if (obj_rst !== 4'hF) begin n_errors++; $display("FAIL reset_obj_rst got %h exp f", obj_rst); end
    if (move !== 4'h0) begin n_errors++; $display("FAIL reset_move got %h exp 0", move); end
    if (initposx !== '0) begin n_errors++; $display("FAIL reset_posx got %h exp 0", initposx); end
    if (initposy !== '0) begin n_errors++; $display("FAIL reset_posy got %h exp 0", initposy); end
    if (initvx !== '0) begin n_errors++; $display("FAIL reset_vx got %h exp 0", initvx); end
    if (initvy !== '0) begin n_errors++; $display("FAIL reset_vy got %h exp 0", initvy); end
    if (initdx !== '0) begin n_errors++; $display("FAIL reset_dx got %h exp 0", initdx); end
    if (addr !== '0) begin n_errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    if (spawn_count !== 16'd0) begin
      n_errors++; $display("FAIL reset_spawn got %0d exp 0", spawn_count);
    end
    rst = 1'b0;
  endtask

  // enable with tick every cycle: slot i first moves DLY*(i+1)+4 edges after enable.
  task automatic test_stagger();
    int first [N];
    for (int i = 0; i < N; i++) first[i] = -1;
    for (int k = 1; k <= 80; k++) begin
      drive_cycle(1'b1, 1'b1, '0);
      for (int i = 0; i < N; i++) if (move[i] === 1'b1 && first[i] < 0) first[i] = k;
      n_checks += 3;
      if (obj_rst !== e_rst) begin
        n_errors++; $display("FAIL stagger_obj_rst k=%0d got %h exp %h", k, obj_rst, e_rst);
      end
      if (spawn_count !== m_spawn) begin
        n_errors++; $display("FAIL stagger_spawn k=%0d got %0d exp %0d", k, spawn_count, m_spawn);
      end
      if (initposx !== e_px || addr !== e_ad) begin
        n_errors++;
        $display("FAIL stagger_launch k=%0d got %h/%h exp %h/%h", k, initposx, addr, e_px, e_ad);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (first[i] != DLY * (i + 1) + 4) begin
        n_errors++;
        $display("FAIL stagger_first_move slot%0d got %0d exp %0d", i, first[i], DLY * (i + 1) + 4);
      end
    end
  endtask

  // All slots leave together and reload the same delay, so they contend in LOAD.
  task automatic test_back_to_back();
    bit reached;
    logic [15:0] exp_sp [5];
    logic [N-1:0] exp_mv [5];
    exp_sp = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd8};
    exp_mv = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    drive_cycle(1'b1, 1'b1, 4'hF);
    reached = 0;
    for (int k = 0; k < 400 && !reached; k++) begin
      drive_cycle(1'b1, 1'b1, '0);
      reached = (m_st[0] == M_LOAD && m_st[1] == M_LOAD && m_st[2] == M_LOAD &&
                 m_st[3] == M_LOAD);
    end
    n_checks++;
    if (!reached) begin
      n_errors++; $display("FAIL b2b_reach_load got timeout exp all LOAD");
      return;
    end
    n_checks++;
    if (spawn_count !== 16'd4) begin
      n_errors++; $display("FAIL b2b_base_spawn got %0d exp 4", spawn_count);
    end
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 1'b1, '0);
      n_checks += 3;
      if (spawn_count !== exp_sp[k]) begin
        n_errors++; $display("FAIL b2b_spawn k=%0d got %0d exp %0d", k, spawn_count, exp_sp[k]);
      end
      if (move !== exp_mv[k]) begin
        n_errors++; $display("FAIL b2b_move k=%0d got %b exp %b", k, move, exp_mv[k]);
      end
      if (initposx !== e_px || initvx !== e_vx || initvy !== e_vy || initdx !== e_dx) begin
        n_errors++; $display("FAIL b2b_launch k=%0d got %h exp %h", k, initposx, e_px);
      end
    end
  endtask

  task automatic test_disable();
    int first;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 1'b1, '0);
      n_checks++;
      if (move !== 4'hF) begin n_errors++; $display("FAIL dis_fly_hold got %b exp 1111", move); end
    end
    drive_cycle(1'b0, 1'b1, 4'b0001);
    n_checks += 2;
    if (move !== 4'b1110) begin n_errors++; $display("FAIL dis_oob_move got %b exp 1110", move); end
    if (obj_rst !== 4'b0001) begin
      n_errors++; $display("FAIL dis_oob_rst got %b exp 0001", obj_rst);
    end
    drive_cycle(1'b0, 1'b1, 4'hF);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 1'b1, 4'hF);
      n_checks += 2;
      if (move !== 4'h0) begin n_errors++; $display("FAIL dis_idle_move got %b exp 0", move); end
      if (spawn_count !== 16'd8) begin
        n_errors++; $display("FAIL dis_idle_spawn got %0d exp 8", spawn_count);
      end
    end
    // Drop enable in WAIT; restart must begin the full stagger again.
    repeat (5) drive_cycle(1'b1, 1'b1, '0);
    drive_cycle(1'b0, 1'b1, '0);
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      drive_cycle(1'b1, 1'b1, '0);
      if (move[0] === 1'b1) first = k;
    end
    n_checks++;
    if (first != DLY + 4) begin
      n_errors++; $display("FAIL dis_wait_restart got %0d exp %0d", first, DLY + 4);
    end
  endtask

  task automatic test_random();
    logic en;
    logic tk;
    logic [N-1:0] ob;
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      tk = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) ob[i] = ($urandom_range(0, 15) == 0);
      drive_cycle(en, tk, ob);
      n_checks += 5;
      if (obj_rst !== e_rst) begin
        n_errors++; $display("FAIL rnd_obj_rst k=%0d got %h exp %h", k, obj_rst, e_rst);
      end
      if (move !== e_move) begin
        n_errors++; $display("FAIL rnd_move k=%0d got %h exp %h", k, move, e_move);
      end
      if (spawn_count !== m_spawn) begin
        n_errors++; $display("FAIL rnd_spawn k=%0d got %0d exp %0d", k, spawn_count, m_spawn);
      end
      if (initposx !== e_px || initposy !== e_py) begin
        n_errors++;
        $display("FAIL rnd_pos k=%0d got %h/%h exp %h/%h", k, initposx, initposy, e_px, e_py);
      end
      if (initvx !== e_vx || initvy !== e_vy || initdx !== e_dx || addr !== e_ad) begin
        n_errors++;
        $display("FAIL rnd_vel_addr k=%0d got %h/%h/%h/%h exp %h/%h/%h/%h", k,
                 initvx, initvy, initdx, addr, e_vx, e_vy, e_dx, e_ad);
      end
    end
  endtask

  task automatic test_async_reset();
    bit flying;
    flying = 0;
    for (int k = 0; k < 600 && !flying; k++) begin
      drive_cycle(1'b1, 1'b1, '0);
      flying = (move !== 4'h0);
    end
    n_checks++;
    if (!flying) begin
      n_errors++; $display("FAIL arst_reach_fly got timeout exp a flying slot");
      return;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (move !== 4'h0) begin n_errors++; $display("FAIL arst_move got %b exp 0000", move); end
    if (obj_rst !== 4'hF) begin n_errors++; $display("FAIL arst_rst got %b exp 1111", obj_rst); end
    if (spawn_count !== 16'd0) begin
      n_errors++; $display("FAIL arst_spawn got %0d exp 0", spawn_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 30; k++) begin
      drive_cycle(1'b1, 1'b1, '0);
      n_checks++;
      if (move !== e_move || obj_rst !== e_rst) begin
        n_errors++; $display("FAIL arst_restart k=%0d got %b exp %b", k, move, e_move);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stagger();
    test_back_to_back();
    test_disable();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
